// File: rtl/load_store_unit.sv
// load_store_unit: turns a load/store instruction (effective address from the ALU) into a
// word-aligned request/acknowledge bus transaction, stalling the core while it is in flight.
// Loads return a byte/halfword/word, sign- or zero-extended, in a registered rdata.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES cycles
// without bus_ack (bus_err pulses, rdata cleared). Undefined: REQ waits forever, bus_err = 0.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_read, mem_write     instruction is a load / store (both set: store)
//   funct3                  access width and sign
//   addr, wdata             effective address, store data
//   rdata                   extended load result (registered)
//   stall                   holds the core while an access is pending (combinational)
//   misaligned, bus_err     one-cycle flags: rejected access, bus timeout
//   bus_req/we/addr/wstrb/wdata, bus_rdata, bus_ack   data bus
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  lsb_q, lsb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        access;
  logic        is_store;
  logic        illegal;
  logic        ack_seen;
  logic        timeout_hit;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign access   = mem_read | mem_write;
  assign is_store = mem_write;
  assign ack_seen = bus_req_q & bus_ack;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counts completed REQ cycles; fires on the last allowed one if no ack arrives.
  assign tmo_d       = (state_q == StReq) ? tmo_q + TmoW'(1) : '0;
  assign timeout_hit = (state_q == StReq) & ~bus_ack & (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    illegal = 1'b0;
    case (funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = addr[0];
      3'b010:  illegal = |addr[1:0];
      3'b100:  illegal = is_store;
      3'b101:  illegal = is_store | addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // Halfword loads are 2-byte aligned, so a byte-granular shift also covers them.
  assign shifted = bus_rdata >> {lsb_q, 3'b000};

  always_comb begin
    load_data = shifted;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'b0, shifted[7:0]};
      3'b101:  load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (access) state_d = illegal ? StDone : StReq;
      StReq:   if (ack_seen || timeout_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    stall = ((state_q == StIdle) & access) | (state_q == StReq);
  end

  // Datapath / registered outputs
  always_comb begin
    lsb_d        = lsb_q;
    funct3_d     = funct3_q;
    rdata_d      = rdata_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_wdata_d  = bus_wdata_q;
    case (state_q)
      StIdle: begin
        if (access) begin
          if (illegal) begin
            misaligned_d = 1'b1;
            rdata_d      = '0;
          end else begin
            bus_req_d  = 1'b1;
            bus_we_d   = is_store;
            bus_addr_d = {addr[31:2], 2'b00};
            lsb_d      = addr[1:0];
            funct3_d   = funct3;
            if (is_store) begin
              case (funct3[1:0])
                2'b00: begin
                  bus_wstrb_d = 4'b0001 << addr[1:0];
                  bus_wdata_d = {4{wdata[7:0]}};
                end
                2'b01: begin
                  bus_wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
                  bus_wdata_d = {2{wdata[15:0]}};
                end
                default: begin
                  bus_wstrb_d = 4'b1111;
                  bus_wdata_d = wdata;
                end
              endcase
            end else begin
              bus_wstrb_d = 4'b0000;
            end
          end
        end
      end
      StReq: begin
        if (ack_seen) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) rdata_d = load_data;
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsb_q        <= '0;
      funct3_q     <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wstrb_q  <= '0;
      bus_wdata_q  <= '0;
    end else begin
      lsb_q        <= lsb_d;
      funct3_q     <= funct3_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign rdata      = rdata_q;
  assign misaligned = misaligned_q;
  assign bus_err    = bus_err_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, misaligned, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    logic [7:0]  stall_cycles;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Responder controls
  int          ack_wait   = 0;
  bit          no_ack     = 1'b0;
  bit          force_ack  = 1'b0;
  logic [31:0] resp_data  = '0;
  int          req_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Bus responder: acks after ack_wait REQ cycles unless no_ack is set.
  initial begin
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        bus_ack = !no_ack && (req_cycles == ack_wait);
        req_cycles++;
      end else begin
        bus_ack    = force_ack;
        req_cycles = 0;
      end
      bus_rdata = resp_data;
    end
  end

  // Monitor: checks bus fields while bus_req is high and the result in the DONE cycle.
  initial begin
    bit       prev_stall = 1'b0;
    bit       prev_req   = 1'b0;
    bit       post_done  = 1'b0;
    bit       have_bus   = 1'b0;
    int       stall_cnt  = 0;
    bus_exp_t be;
    res_exp_t re;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_req   = 1'b0;
        post_done  = 1'b0;
        have_bus   = 1'b0;
        stall_cnt  = 0;
      end else begin
        if (post_done) begin
          check("misaligned_one_cycle", {31'b0, misaligned}, 32'd0);
          check("bus_err_one_cycle", {31'b0, bus_err}, 32'd0);
          post_done = 1'b0;
        end
        if (bus_req && !prev_req) begin
          if (bus_q.size() == 0) begin
            note_fail("unexpected_bus_req");
            have_bus = 1'b0;
          end else begin
            be       = bus_q.pop_front();
            have_bus = 1'b1;
          end
        end
        if (bus_req && have_bus) begin
          check("bus_addr", bus_addr, be.addr);
          check("bus_we", {31'b0, bus_we}, {31'b0, be.we});
          check("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, be.wstrb});
          if (be.we) check("bus_wdata", bus_wdata, be.wdata);
        end
        prev_req = bus_req;
        if (stall) begin
          stall_cnt++;
          prev_stall = 1'b1;
        end else if (prev_stall) begin
          if (res_q.size() == 0) begin
            note_fail("unexpected_completion");
          end else begin
            re = res_q.pop_front();
            check("rdata", rdata, re.rdata);
            check("misaligned", {31'b0, misaligned}, {31'b0, re.mis});
            check("bus_err", {31'b0, bus_err}, {31'b0, re.err});
            check("stall_cycles", stall_cnt, {24'b0, re.stall_cycles});
            check("bus_req_done", {31'b0, bus_req}, 32'd0);
          end
          post_done  = 1'b1;
          prev_stall = 1'b0;
          stall_cnt  = 0;
          have_bus   = 1'b0;
        end
      end
    end
  end

  // Issue one instruction (called just after a rising edge) and hold it until DONE.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                       input int wt, input bit has_bus, input logic [31:0] e_addr,
                       input logic [3:0] e_strb, input logic [31:0] e_wdata,
                       input logic [31:0] e_rdata, input logic e_mis, input logic e_err,
                       input int e_stall);
    bit done = 1'b0;
    if (has_bus) bus_q.push_back('{addr: e_addr, we: wr, wstrb: e_strb, wdata: e_wdata});
    res_q.push_back('{rdata: e_rdata, mis: e_mis, err: e_err, stall_cycles: 8'(e_stall)});
    resp_data = rsp;
    ack_wait  = wt;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (!stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) note_fail("stall_timeout");
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_misaligned"}, {31'b0, misaligned}, 32'd0);
    check({tag, "_bus_err"}, {31'b0, bus_err}, 32'd0);
    check({tag, "_bus_req"}, {31'b0, bus_req}, 32'd0);
    check({tag, "_bus_we"}, {31'b0, bus_we}, 32'd0);
    check({tag, "_bus_addr"}, bus_addr, 32'd0);
    check({tag, "_bus_wstrb"}, {28'b0, bus_wstrb}, 32'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check({tag, "_stall"}, {31'b0, stall}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = '0;
    addr      = '0;
    wdata     = '0;
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //    rd wr  f3      addr          wdata         bus_rdata     wt bus e_addr        strb     e_wdata       e_rdata       mis err stl
    issue(1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'h1122_3344, 0, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'h1122_3344, 0, 0, 2);
    issue(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80, 0, 0, 2);
    issue(1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080, 0, 0, 2);
    issue(1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_FFFF, 1, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_80FF, 0, 0, 3);
    issue(1, 0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_FFFF, 0, 1, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_80FF, 0, 0, 2);
    issue(0, 1, 3'b001, 32'h0000_0202, 32'hCAFE_BEEF, 32'h0,       3, 1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0000_80FF, 0, 0, 5);
    issue(0, 1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,       0, 1, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0000_80FF, 0, 0, 2);
    issue(1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_0000, 1, 0, 1);
    issue(1, 0, 3'b001, 32'h0000_0105, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_0000, 1, 0, 1);
    issue(1, 0, 3'b011, 32'h0000_0108, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_0000, 1, 0, 1);
    issue(0, 1, 3'b100, 32'h0000_0108, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_0000, 1, 0, 1);
    issue(1, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,       0, 1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0, 2);
    issue(1, 0, 3'b010, 32'h0000_0104, 32'h0,        32'hA5A5_5A5A, 2, 1, 32'h0000_0104, 4'b0000, 32'h0,        32'hA5A5_5A5A, 0, 0, 4);

`ifdef LSU_TIMEOUT_EN
    no_ack = 1'b1;
    issue(1, 0, 3'b010, 32'h0000_0080, 32'h0,        32'h0,        0, 1, 32'h0000_0080, 4'b0000, 32'h0,        32'h0000_0000, 0, 1, 5);
    no_ack = 1'b0;
`endif

    // Reset while a load is waiting for its ack.
    no_ack    = 1'b1;
    bus_q.push_back('{addr: 32'h0000_0040, we: 1'b0, wstrb: 4'b0000, wdata: 32'h0});
    mem_read  = 1'b1;
    mem_write = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h0000_0040;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("req_before_reset", {31'b0, bus_req}, 32'd1);
    mem_read = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    no_ack    = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    // Stray ack with no request pending must be ignored.
    repeat (2) @(posedge clk);
    #1;
    check("late_ack_bus_req", {31'b0, bus_req}, 32'd0);
    check("late_ack_rdata", rdata, 32'd0);
    check("late_ack_stall", {31'b0, stall}, 32'd0);
    force_ack = 1'b0;
    @(posedge clk);
    #1;
    issue(0, 1, 3'b010, 32'h0000_0000, 32'h1234_5678, 32'h0,       0, 1, 32'h0000_0000, 4'b1111, 32'h1234_5678, 32'h0000_0000, 0, 0, 2);

    repeat (3) @(posedge clk);
    check("bus_queue_drained", bus_q.size(), 32'd0);
    check("res_queue_drained", res_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit that sits directly downstream of the ALU. It takes the ALU result as the effective address and turns a load or store instruction into a word-aligned request/acknowledge transaction on the data bus. While the access is in flight it stalls the core. On loads it returns the byte, halfword or word, sign- or zero-extended.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting for bus_ack; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store.
- funct3  in  3  access width/sign.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- addr  in  32  effective address (ALU result).
- wdata  in  32  store data (rs2).
- rdata  out  32  extended load result; registered.
- stall  out  1  holds PC and register write-enable; combinational.
- misaligned  out  1  one-cycle flag: access rejected.
- bus_err  out  1  one-cycle flag: bus timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  {addr[31:2], 2'b00}.
- bus_wstrb  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read word.
- bus_ack  in  1  transaction complete; sampled only while bus_req=1.

## Operation
- FSM states:
  - IDLE to REQ: on (mem_read | mem_write), a legal access. Latch addr[1:0], funct3 and direction; drive the bus registers.
  - IDLE to DONE: on an illegal access. Set misaligned=1 and rdata=0; issue no bus request.
  - REQ to DONE: on bus_ack.
  - DONE to IDLE: always.
- Illegal accesses:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - funct3 ∈ {011, 110, 111}.
  - Stores with funct3 ∈ {100, 101}.
- Simultaneous mem_read and mem_write: treated as a store.
- stall = (IDLE & (mem_read|mem_write)) | REQ. stall is 0 in DONE, so the core retires the instruction at the end of DONE. DONE always returns to IDLE, so the same instruction is never reissued.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011; bus_wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; bus_wdata = wdata.
- Loads:
  - Shift bus_rdata right by 8·addr[1:0] (halfword: by 16·addr[1]).
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Capture into rdata on the ack edge. rdata holds until the next completed load, misaligned access, or timeout.
- Load bus cycles drive wstrb=0000 and bus_we=0.

## Timing
- Reset value of every output is 0 except stall, which is combinational: rdata, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata all reset to 0.
- Reset mid-transaction: the FSM returns to IDLE and bus_req drops immediately. A late bus_ack is ignored.
- Legal access, request seen in cycle 0:
  - bus_req rises in cycle 1.
  - With ack in cycle 1: DONE in cycle 2; stall is high in cycles 0–1.
  - Minimum latency is 3 cycles including DONE.
  - Each additional wait cycle adds 1.
- bus_addr, bus_we, bus_wstrb, bus_wdata are stable from bus_req rise until the ack edge. bus_req falls on entry to DONE.
- Misaligned access: stall high in cycle 0; misaligned=1 in cycle 1 (DONE) only.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter runs while in REQ.
  - After TIMEOUT_CYCLES cycles without ack: drop bus_req, go to DONE with bus_err=1 and rdata=0.
  - A counter width of $clog2(TIMEOUT_CYCLES+1) is sufficient.
- LSU_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; bus_err is tied 0.

## Test plan
- LW from addr 0x100, bus_rdata=0x11223344, ack on first REQ cycle:
  - bus_addr=0x100, wstrb=0000.
  - stall high for 2 cycles, then rdata=0x11223344.
- LB from addr 0x103 with rdata 0x80FFFFFF: rdata=0xFFFFFF80. Same access as LBU: rdata=0x00000080.
- SH from addr 0x202 with wdata 0xCAFEBEEF:
  - bus_addr=0x200, wstrb=1100, bus_wdata=0xBEEFBEEF, bus_we=1.
  - Fields held stable across 3 wait cycles.
- LW from addr 0x101:
  - No bus_req.
  - misaligned=1 for exactly 1 cycle, rdata=0.
  - stall high 1 cycle.
- rst_n asserted low during REQ with bus_req=1:
  - bus_req=0 immediately and all outputs 0.
  - After release, a new SW to 0x0 completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, never ack:
  - bus_err=1 in the cycle after the 4th REQ cycle.
  - bus_req drops; stall releases.
